// File: rtl/fast_controls_gen.sv
// Orbit-aligned fast-control generator: NCH delayed/masked QIE reset pulses plus one WTE pulse per orbit event.
// Orbit events come from an internal period counter, a synchronised aux input or a software single-shot.
module fast_controls_gen #(
  parameter int unsigned CNT_W = 12,
  parameter int unsigned NCH   = 4,
  parameter int unsigned DLY_W = 4
) (
  input  logic                   clk,
  input  logic                   reset_in,
  input  logic                   enable,
  input  logic [1:0]             mode,
  input  logic [CNT_W-1:0]       period,
  input  logic [CNT_W-1:0]       wte_offset,
  input  logic [NCH*DLY_W-1:0]   ch_delay,
  input  logic [NCH-1:0]         ch_mask,
  input  logic                   aux_in,
  input  logic                   single_shot,
  output logic [NCH-1:0]         qie_reset_out,
  output logic                   wte_out,
  output logic [15:0]            orbit_count,
  output logic                   busy,
  output logic                   err_missed
);

  localparam int unsigned DEPTH = 1 << DLY_W;

  typedef enum logic [1:0] {
    MODE_INT  = 2'd0,
    MODE_AUX  = 2'd1,
    MODE_SHOT = 2'd2,
    MODE_IDLE = 2'd3
  } mode_e;

  mode_e            mode_c;
  logic [1:0]       mode_q;
  logic             aux_s1, aux_s2, aux_prev, ss_prev;
  logic [CNT_W-1:0] cnt, cnt_next_c;
  logic             ev, ev_next_c;
  logic [DEPTH-2:0] dline;
  logic [DEPTH-1:0] taps_c;
  logic [CNT_W-1:0] wte_cnt, wte_cnt_next_c;
  logic             busy_next_c, wte_next_c, err_set_c;
  logic [NCH-1:0]   qie_next_c;
  logic             flush_c, aux_rise_c, ss_rise_c, cnt_hit_c;

  assign mode_c     = mode_e'(mode);
  assign flush_c    = !enable || (mode != mode_q);
  assign aux_rise_c = aux_s2 & ~aux_prev;
  assign ss_rise_c  = single_shot & ~ss_prev;
  assign cnt_hit_c  = (period != '0) && (cnt == period - CNT_W'(1));
  // Tap 0 is ev itself, so a zero delay emits one cycle after ev.
  assign taps_c     = {dline, ev};

  // Event source selection and internal period counter.
  always_comb begin
    ev_next_c  = 1'b0;
    cnt_next_c = cnt;
    unique case (mode_c)
      MODE_INT: begin
        ev_next_c = cnt_hit_c;
        if (period != '0) cnt_next_c = cnt_hit_c ? '0 : cnt + CNT_W'(1);
      end
      MODE_AUX:  ev_next_c = aux_rise_c;
      MODE_SHOT: ev_next_c = ss_rise_c;
      default:   ev_next_c = 1'b0;
    endcase
  end

  // Per-channel tap select; mask applies at output time.
  always_comb begin
    qie_next_c = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      qie_next_c[i] = ch_mask[i] & taps_c[ch_delay[i*DLY_W +: DLY_W]];
    end
  end

  // WTE down-counter: a new event always restarts it and drops any pending WTE.
  always_comb begin
    wte_cnt_next_c = wte_cnt;
    busy_next_c    = busy;
    wte_next_c     = 1'b0;
    err_set_c      = 1'b0;
    if (ev) begin
      err_set_c = busy;
      if (wte_offset == '0) begin
        wte_next_c  = 1'b1;
        busy_next_c = 1'b0;
      end else begin
        wte_cnt_next_c = wte_offset - CNT_W'(1);
        busy_next_c    = 1'b1;
      end
    end else if (busy) begin
      if (wte_cnt == '0) begin
        wte_next_c  = 1'b1;
        busy_next_c = 1'b0;
      end else begin
        wte_cnt_next_c = wte_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      mode_q        <= 2'd0;
      aux_s1        <= 1'b0;
      aux_s2        <= 1'b0;
      aux_prev      <= 1'b0;
      ss_prev       <= 1'b0;
      cnt           <= '0;
      ev            <= 1'b0;
      dline         <= '0;
      wte_cnt       <= '0;
      busy          <= 1'b0;
      wte_out       <= 1'b0;
      qie_reset_out <= '0;
      orbit_count   <= 16'd0;
      err_missed    <= 1'b0;
    end else begin
      mode_q <= mode;
      aux_s1 <= aux_in;
      aux_s2 <= aux_s1;
      if (ev) orbit_count <= orbit_count + 16'd1;
      if (flush_c) begin
        // Edge detectors capture the current level so a held input cannot fake an edge.
        aux_prev      <= aux_s2;
        ss_prev       <= single_shot;
        cnt           <= '0;
        ev            <= 1'b0;
        dline         <= '0;
        wte_cnt       <= '0;
        busy          <= 1'b0;
        wte_out       <= 1'b0;
        qie_reset_out <= '0;
      end else begin
        aux_prev      <= aux_s2;
        ss_prev       <= single_shot;
        cnt           <= cnt_next_c;
        ev            <= ev_next_c;
        dline         <= taps_c[DEPTH-2:0];
        wte_cnt       <= wte_cnt_next_c;
        busy          <= busy_next_c;
        wte_out       <= wte_next_c;
        qie_reset_out <= qie_next_c;
        if (err_set_c) err_missed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fast_controls_gen.sv
// Directed bench for fast_controls_gen: expected pulses are queued when stimulus is driven
// and compared every cycle by a negedge monitor; register state is checked at directed points.
module tb_fast_controls_gen;

  logic        clk;
  logic        reset_in, enable, aux_in, single_shot;
  logic [1:0]  mode;
  logic [11:0] period, wte_offset;
  logic [15:0] ch_delay;
  logic [3:0]  ch_mask;
  logic [3:0]  qie_reset_out;
  logic        wte_out, busy, err_missed;
  logic [15:0] orbit_count;

  typedef struct {
    int         cyc;
    logic [3:0] qie;
    logic       wte;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc   = 0;
  bit   mon_on = 1'b0;

  fast_controls_gen #(.CNT_W(12), .NCH(4), .DLY_W(4)) dut (
    .clk(clk), .reset_in(reset_in), .enable(enable), .mode(mode),
    .period(period), .wte_offset(wte_offset), .ch_delay(ch_delay), .ch_mask(ch_mask),
    .aux_in(aux_in), .single_shot(single_shot),
    .qie_reset_out(qie_reset_out), .wte_out(wte_out), .orbit_count(orbit_count),
    .busy(busy), .err_missed(err_missed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic push(input int c, input logic [3:0] q, input logic w);
    exp_t e;
    e.cyc = c;
    e.qie = q;
    e.wte = w;
    exp_q.push_back(e);
  endtask

  // Expected pulses of one orbit event at cycle ev under the current mask/delays.
  task automatic push_orbit(input int ev, input int woff);
    logic [15:0] d;
    d = ch_delay;
    for (int i = 0; i < 4; i++)
      if (ch_mask[i]) push(ev + int'(d[i*4 +: 4]) + 1, 4'(1 << i), 1'b0);
    if (woff >= 0) push(ev + woff + 1, 4'b0000, 1'b1);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every cycle: outputs must equal the OR of what is scheduled for this cycle (else zero).
  always @(negedge clk) begin
    logic [3:0] eq;
    logic       ew;
    if (mon_on) begin
      eq = 4'b0000;
      ew = 1'b0;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].cyc == cyc) begin
          eq = eq | exp_q[i].qie;
          ew = ew | exp_q[i].wte;
          exp_q.delete(i);
        end
      end
      chk("qie_reset_out", 32'(qie_reset_out), 32'(eq));
      chk("wte_out", 32'(wte_out), 32'(ew));
    end
  end

  initial begin
    int t0, r, s, p, q, x, ev;
    reset_in = 1'b0; enable = 1'b0; mode = 2'd0; period = 12'd10; wte_offset = 12'd3;
    ch_delay = {4'd3, 4'd2, 4'd1, 4'd0}; ch_mask = 4'hF; aux_in = 1'b0; single_shot = 1'b0;
    #2 reset_in = 1'b1;
    #1;
    chk("reset_qie", 32'(qie_reset_out), 32'd0);
    chk("reset_orbit", 32'(orbit_count), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err", 32'(err_missed), 32'd0);
    mon_on = 1'b1;
    step(3);
    reset_in = 1'b0;

    // Internal periodic mode, period 10, offset 3.
    step(1);
    t0 = cyc;
    enable = 1'b1;
    push_orbit(t0 + 10, 3);
    push_orbit(t0 + 20, 3);
    push_orbit(t0 + 30, 3);
    step(10);
    chk("int_orbit_before_ev", 32'(orbit_count), 32'd0);
    step(1);
    chk("int_orbit_first", 32'(orbit_count), 32'd1);
    step(1);
    chk("int_busy_set", 32'(busy), 32'd1);
    step(2);
    chk("int_busy_clear", 32'(busy), 32'd0);
    step(21);
    chk("int_orbit_three", 32'(orbit_count), 32'd3);
    enable = 1'b0;

    // External aux mode: single edge, then two edges while WTE pending.
    step(1);
    mode = 2'd1;
    step(1);
    enable = 1'b1;
    step(2);
    r = cyc;
    aux_in = 1'b1;
    push_orbit(r + 3, 3);
    step(4);
    aux_in = 1'b0;
    step(10);
    chk("aux_orbit", 32'(orbit_count), 32'd4);
    chk("aux_err_clean", 32'(err_missed), 32'd0);
    wte_offset = 12'd20;
    step(1);
    r = cyc;
    aux_in = 1'b1;
    push_orbit(r + 3, -1);
    push_orbit(r + 7, 20);
    step(2);
    aux_in = 1'b0;
    step(2);
    aux_in = 1'b1;
    step(2);
    aux_in = 1'b0;
    step(1);
    chk("aux_err_before", 32'(err_missed), 32'd0);
    step(1);
    chk("aux_err_set", 32'(err_missed), 32'd1);
    chk("aux_busy_restart", 32'(busy), 32'd1);
    step(21);
    chk("aux_busy_done", 32'(busy), 32'd0);
    chk("aux_orbit_two_more", 32'(orbit_count), 32'd6);
    enable = 1'b0;

    // Single-shot: a long pulse gives one event; other modes ignore it.
    step(1);
    mode = 2'd2;
    wte_offset = 12'd3;
    step(1);
    enable = 1'b1;
    step(2);
    s = cyc;
    single_shot = 1'b1;
    push_orbit(s + 1, 3);
    step(5);
    single_shot = 1'b0;
    step(5);
    chk("shot_orbit", 32'(orbit_count), 32'd7);
    period = 12'd0;
    mode = 2'd0;
    step(2);
    single_shot = 1'b1;
    step(1);
    single_shot = 1'b0;
    step(1);
    single_shot = 1'b1;
    step(1);
    single_shot = 1'b0;
    mode = 2'd3;
    step(1);
    aux_in = 1'b1;
    step(3);
    aux_in = 1'b0;
    step(5);
    chk("no_extra_events", 32'(orbit_count), 32'd7);
    enable = 1'b0;

    // Period 2 with channel 0 delayed 5, then flush while busy with pulses in flight.
    step(1);
    period = 12'd2; mode = 2'd0; wte_offset = 12'd1;
    ch_delay = {4'd3, 4'd2, 4'd1, 4'd5}; ch_mask = 4'b0001;
    step(1);
    p = cyc;
    enable = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      ev = p + 2 * k;
      if (ev + 6 <= p + 17) push(ev + 6, 4'b0001, 1'b0);
      if (ev + 2 <= p + 17) push(ev + 2, 4'b0000, 1'b1);
    end
    step(17);
    chk("flush_busy_before", 32'(busy), 32'd1);
    enable = 1'b0;
    step(1);
    chk("flush_busy_after", 32'(busy), 32'd0);
    chk("flush_qie", 32'(qie_reset_out), 32'd0);
    chk("overlap_orbit", 32'(orbit_count), 32'd15);
    step(3);
    period = 12'd10; wte_offset = 12'd3;
    ch_delay = {4'd3, 4'd2, 4'd1, 4'd0}; ch_mask = 4'hF;
    step(1);
    q = cyc;
    enable = 1'b1;
    push(q + 11, 4'b0001, 1'b0);
    push(q + 12, 4'b0010, 1'b0);
    step(10);
    chk("reenable_orbit", 32'(orbit_count), 32'd15);

    // Asynchronous reset between edges, mid-event.
    step(3);
    chk("pre_reset_qie", 32'(qie_reset_out), 32'b0100);
    chk("pre_reset_orbit", 32'(orbit_count), 32'd16);
    #1 reset_in = 1'b1;
    #1;
    chk("async_reset_qie", 32'(qie_reset_out), 32'd0);
    chk("async_reset_busy", 32'(busy), 32'd0);
    chk("async_reset_orbit", 32'(orbit_count), 32'd0);
    chk("async_reset_err", 32'(err_missed), 32'd0);
    step(2);
    reset_in = 1'b0;
    x = cyc;
    push_orbit(x + 10, 3);
    step(5);
    chk("restart_orbit_zero", 32'(orbit_count), 32'd0);
    step(6);
    chk("restart_orbit_one", 32'(orbit_count), 32'd1);
    step(4);
    enable = 1'b0;
    step(5);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
